mpshare: RTL and testbench

- Shares one pipelined 24-bit signed Q1.23 multiplier (mpemu) between NCH mixer channel requesters.
- Arbitrates issue slots and launches at most one multiply per clk.
- Tracks the owner of each in-flight product through the multiplier latency, then returns the product to that owner with a one-hot valid.
- Sits between the per-channel gain/mix engines and the single mpemu instance; clk is the 24.576 MHz audio clock.

---
 rtl/mpshare_pkg.sv | 35 +++
 rtl/mpshare_rr.sv | 40 ++++
 rtl/mpshare.sv | 116 +++++++++++
 tb/tb_mpshare.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpshare_pkg.sv
// mpshare shared constants, return-tag type and small index helpers.
// Build option: MPSHARE_ROUNDROBIN_EN selects rotating priority (else fixed).
package mpshare_pkg;

   localparam int NCH_DEF        = 4;
   localparam int W_DEF          = 24;
   localparam int MP_LATENCY_DEF = 6;

   // Tag id is sized for the largest supported channel count.
   localparam int NCH_MAX = 8;
   localparam int ID_W    = $clog2(NCH_MAX);

   typedef struct packed {
      logic            v;
      logic [ID_W-1:0] id;
   } tag_t;

   localparam tag_t TAG_IDLE = '{v: 1'b0, id: '0};

   function automatic logic id_hit(
      input logic [ID_W-1:0] id,
      input int              k
   );
      return id == ID_W'(k);
   endfunction

   // Next pointer after a grant to id, wrapping at n channels.
   function automatic logic [ID_W-1:0] id_next(
      input logic [ID_W-1:0] id,
      input int              n
   );
      return (id == ID_W'(n - 1)) ? '0 : id + 1'b1;
   endfunction

endpackage

// File: rtl/mpshare_rr.sv
// mpshare_rr: combinational picker, req -> one-hot grant and its index.
// MPSHARE_ROUNDROBIN_EN: search starts at ptr; otherwise lowest index wins.
module mpshare_rr
   import mpshare_pkg::*;
#(
   parameter int NCH = NCH_DEF
) (
   input  logic [NCH-1:0]  req,
`ifdef MPSHARE_ROUNDROBIN_EN
   input  logic [ID_W-1:0] ptr,
`endif
   output logic [NCH-1:0]  gnt,
   output logic [ID_W-1:0] idx,
   output logic            hit
);

   always_comb begin
      gnt = '0;
      idx = '0;
      hit = 1'b0;
`ifdef MPSHARE_ROUNDROBIN_EN
      // First pass covers ptr..NCH-1, the second wraps to 0..ptr-1.
      for (int k = 0; k < NCH; k++) begin
         if (!hit && req[k] && (ID_W'(k) >= ptr)) begin
            hit    = 1'b1;
            gnt[k] = 1'b1;
            idx    = ID_W'(k);
         end
      end
`endif
      for (int k = 0; k < NCH; k++) begin
         if (!hit && req[k]) begin
            hit    = 1'b1;
            gnt[k] = 1'b1;
            idx    = ID_W'(k);
         end
      end
   end

endmodule

// File: rtl/mpshare.sv
// mpshare: shares one pipelined Q1.23 multiplier (mpemu) among NCH channels.
// Build option: MPSHARE_ROUNDROBIN_EN (rotating priority; default fixed).
// Ports:
//   clk, rst                synchronous active-high reset
//   req_i[NCH]              level requests, held until acked
//   mpcand_i/mplier_i       channel k operands at [k*W +: W]
//   ack_o[NCH]              combinational one-hot grant
//   mpcand_o/mplier_o       registered operands to mpemu
//   mprod_i                 product from mpemu
//   mprod_o, valid_o[NCH]   registered product and one-hot owner strobe
module mpshare
   import mpshare_pkg::*;
#(
   parameter int NCH        = NCH_DEF,
   parameter int W          = W_DEF,
   parameter int MP_LATENCY = MP_LATENCY_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   req_i,
   input  logic [NCH*W-1:0] mpcand_i,
   input  logic [NCH*W-1:0] mplier_i,
   output logic [NCH-1:0]   ack_o,
   output logic [W-1:0]     mpcand_o,
   output logic [W-1:0]     mplier_o,
   input  logic [W-1:0]     mprod_i,
   output logic [W-1:0]     mprod_o,
   output logic [NCH-1:0]   valid_o
);

   logic [NCH-1:0]  gnt;
   logic [ID_W-1:0] gidx;
   logic            ghit;
   logic            issue;
   logic [W-1:0]    cand_sel;
   logic [W-1:0]    plier_sel;
   logic [NCH-1:0]  ret_oh;

   // tag_q[0] travels with mpcand_o/mplier_o; tag_q[MP_LATENCY]
   // then lines up with the matching product on mprod_i.
   tag_t tag_q [0:MP_LATENCY];

`ifdef MPSHARE_ROUNDROBIN_EN
   logic [ID_W-1:0] ptr;
`endif

   mpshare_rr #(
      .NCH (NCH)
   ) u_rr (
      .req (req_i),
`ifdef MPSHARE_ROUNDROBIN_EN
      .ptr (ptr),
`endif
      .gnt (gnt),
      .idx (gidx),
      .hit (ghit)
   );

   assign issue = ghit & ~rst;
   assign ack_o = gnt & {NCH{~rst}};

   always_comb begin
      cand_sel  = '0;
      plier_sel = '0;
      for (int k = 0; k < NCH; k++) begin
         if (gnt[k]) begin
            cand_sel  = mpcand_i[k*W +: W];
            plier_sel = mplier_i[k*W +: W];
         end
      end
   end

   always_comb begin
      ret_oh = '0;
      for (int k = 0; k < NCH; k++) begin
         ret_oh[k] = tag_q[MP_LATENCY].v &
                     id_hit(tag_q[MP_LATENCY].id, k);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mpcand_o <= '0;
         mplier_o <= '0;
         mprod_o  <= '0;
         valid_o  <= '0;
         for (int i = 0; i <= MP_LATENCY; i++) begin
            tag_q[i] <= TAG_IDLE;
         end
      end else begin
         if (issue) begin
            mpcand_o <= cand_sel;
            mplier_o <= plier_sel;
         end
         tag_q[0] <= '{v: issue, id: gidx};
         for (int i = 1; i <= MP_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
         if (tag_q[MP_LATENCY].v) begin
            mprod_o <= mprod_i;
         end
         valid_o <= ret_oh;
      end
   end

`ifdef MPSHARE_ROUNDROBIN_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (issue) begin
         ptr <= id_next(gidx, NCH);
      end
   end
`endif

endmodule

// File: tb/tb_mpshare.sv
// tb_mpshare: directed tables, hand sequences and random traffic for mpshare.
// A cycle-level reference model predicts every ack, valid and product.
`timescale 1ns/1ps
module tb_mpshare;

   localparam int NCH = 4;
   localparam int W   = 24;
   localparam int LAT = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NCH-1:0]   req_i = '0;
   logic [NCH*W-1:0] mpcand_i = '0;
   logic [NCH*W-1:0] mplier_i = '0;
   logic [NCH-1:0]   ack_o;
   logic [W-1:0]     mpcand_o;
   logic [W-1:0]     mplier_o;
   logic [W-1:0]     mprod_i;
   logic [W-1:0]     mprod_o;
   logic [NCH-1:0]   valid_o;

   always #20 clk = ~clk;

   mpshare #(
      .NCH        (NCH),
      .W          (W),
      .MP_LATENCY (LAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_i    (req_i),
      .mpcand_i (mpcand_i),
      .mplier_i (mplier_i),
      .ack_o    (ack_o),
      .mpcand_o (mpcand_o),
      .mplier_o (mplier_o),
      .mprod_i  (mprod_i),
      .mprod_o  (mprod_o),
      .valid_o  (valid_o)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   function automatic logic [W-1:0] q123(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      logic signed [2*W-1:0] p;
      p = $signed(a) * $signed(b);
      p = p >>> (W - 1);
      return p[W-1:0];
   endfunction

   function automatic logic [NCH-1:0] oh(input int k);
      logic [NCH-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   function automatic int idx_of(input logic [NCH-1:0] v);
      for (int i = 0; i < NCH; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int pick(input logic [NCH-1:0] r, input int p);
      for (int i = 0; i < NCH; i++) begin
         if (r[(p + i) % NCH]) return (p + i) % NCH;
      end
      return -1;
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // mpemu stand-in: product valid MP_LATENCY cycles after operands.
   logic [W-1:0] emu [0:LAT-1];
   always @(posedge clk) begin
      emu[0] <= q123(mpcand_o, mplier_o);
      for (int i = 1; i < LAT; i++) emu[i] <= emu[i-1];
   end
   assign mprod_i = emu[LAT-1];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } op_t;

   typedef struct {
      int           cyc;
      int           k;
      logic [W-1:0] p;
   } ev_t;

   typedef struct {
      int           due;
      int           k;
      logic [W-1:0] p;
   } ret_t;

   op_t  pend [NCH][$];
   ev_t  ack_hist[$];
   ev_t  val_hist[$];
   ret_t sb[$];

   // Requester behaviour: hold req with the head op until acked.
   logic [NCH-1:0] acked;
   initial forever begin
      @(negedge clk);
      acked = ack_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < NCH; k++) begin
         if (acked[k] && pend[k].size() > 0) void'(pend[k].pop_front());
         if (pend[k].size() > 0) begin
            req_i[k] = 1'b1;
            mpcand_i[k*W +: W] = pend[k][0].a;
            mplier_i[k*W +: W] = pend[k][0].b;
         end else begin
            req_i[k] = 1'b0;
            mpcand_i[k*W +: W] = W'($urandom);
            mplier_i[k*W +: W] = W'($urandom);
         end
      end
   end

   // Reference model, compared every cycle once reset has been seen.
   int           ptr_m = 0;
   int           exp_k = -1;
   bit           armed = 1'b0;
   logic [W-1:0] last_p = '0;
   logic [W-1:0] exp_a, exp_b;
   initial forever begin
      @(negedge clk);
      exp_k = rst ? -1 : pick(req_i, ptr_m);
      if (exp_k >= 0) begin
         exp_a = mpcand_i[exp_k*W +: W];
         exp_b = mplier_i[exp_k*W +: W];
      end
      if (armed) begin
         check("ack", 32'(ack_o), exp_k < 0 ? 32'd0 : 32'(oh(exp_k)));
         if (sb.size() > 0 && sb[0].due == cyc) begin
            check("valid", 32'(valid_o), 32'(oh(sb[0].k)));
            check("mprod", 32'(mprod_o), 32'(sb[0].p));
            last_p = sb[0].p;
            void'(sb.pop_front());
         end else begin
            check("valid_idle", 32'(valid_o), 32'd0);
            check("mprod_hold", 32'(mprod_o), 32'(last_p));
         end
      end
      if (ack_o != '0) ack_hist.push_back('{cyc, idx_of(ack_o), '0});
      if (valid_o != '0) val_hist.push_back('{cyc, idx_of(valid_o), mprod_o});
      @(posedge clk);
      if (rst) begin
         sb.delete();
         ptr_m  = 0;
         last_p = '0;
         armed  = 1'b1;
      end else if (armed && exp_k >= 0) begin
         sb.push_back('{cyc + LAT + 2, exp_k, q123(exp_a, exp_b)});
`ifdef MPSHARE_ROUNDROBIN_EN
         ptr_m = (exp_k + 1) % NCH;
`endif
      end
      cyc++;
   end

   function automatic bit busy();
      for (int k = 0; k < NCH; k++) if (pend[k].size() > 0) return 1'b1;
      return sb.size() > 0;
   endfunction

   task automatic tick(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #2;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (busy() && t < 200) begin
         @(posedge clk);
         #2;
         t++;
      end
      check("drain", 32'(busy()), 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
   endtask

   task automatic clear_hist();
      ack_hist.delete();
      val_hist.delete();
   endtask

   task automatic push(input int k, input logic [W-1:0] a,
                       input logic [W-1:0] b);
      pend[k].push_back('{a, b});
   endtask

   task automatic wait_val(input int n);
      int t;
      t = 0;
      while (val_hist.size() < n && t < 40) begin
         @(posedge clk);
         #2;
         t++;
      end
      check("val_seen", 32'(val_hist.size() >= n), 32'd1);
   endtask

   typedef struct {
      int           ch;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] p;
   } vec_t;

   vec_t vt [7];
   int   cnt [NCH];
   int   got [NCH];
   int   t;
   int   k;

   initial begin
      #400000;
      $display("FAIL watchdog cyc=%0d expired", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{0, 24'h100000, 24'h123456, 24'h02468a};
      vt[1] = '{2, 24'hffffff, 24'h7fffff, 24'hffffff};
      vt[2] = '{1, 24'h400000, 24'h400000, 24'h200000};
      vt[3] = '{3, 24'h800000, 24'h800000, 24'h800000};
      vt[4] = '{1, 24'h7fffff, 24'h7fffff, 24'h7ffffe};
      vt[5] = '{0, 24'hc00000, 24'h400000, 24'he00000};
      vt[6] = '{3, 24'h000001, 24'hffffff, 24'hffffff};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_mpcand", 32'(mpcand_o), 32'd0);
      check("rst_mplier", 32'(mplier_o), 32'd0);
      check("rst_mprod", 32'(mprod_o), 32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
      tick(1);

      // Single requester vectors with known products.
      for (int i = 0; i < 7; i++) begin
         clear_hist();
         push(vt[i].ch, vt[i].a, vt[i].b);
         wait_val(1);
         if (val_hist.size() > 0 && ack_hist.size() > 0) begin
            check("vec_ack_ch", 32'(ack_hist[0].k), 32'(vt[i].ch));
            check("vec_val_ch", 32'(val_hist[0].k), 32'(vt[i].ch));
            check("vec_prod", 32'(val_hist[0].p), 32'(vt[i].p));
            check("vec_lat", 32'(val_hist[0].cyc - ack_hist[0].cyc),
                  32'(LAT + 2));
         end
         drain();
      end

      // ch2 holds req for four back-to-back operations.
      clear_hist();
      for (int i = 0; i < 4; i++) push(2, W'($urandom), W'($urandom));
      drain();
      check("burst_acks", 32'(ack_hist.size()), 32'd4);
      check("burst_vals", 32'(val_hist.size()), 32'd4);
      if (ack_hist.size() == 4 && val_hist.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check("burst_ack_ch", 32'(ack_hist[i].k), 32'd2);
            check("burst_ack_cyc", 32'(ack_hist[i].cyc - ack_hist[0].cyc),
                  32'(i));
            check("burst_val_ch", 32'(val_hist[i].k), 32'd2);
            check("burst_val_cyc", 32'(val_hist[i].cyc - ack_hist[0].cyc),
                  32'(LAT + 2 + i));
         end
      end

      // All four request together straight out of reset.
      do_reset();
      clear_hist();
      for (int i = 0; i < NCH; i++) push(i, W'($urandom), W'($urandom));
      drain();
      check("all4_acks", 32'(ack_hist.size()), 32'(NCH));
      check("all4_vals", 32'(val_hist.size()), 32'(NCH));
      if (ack_hist.size() == NCH && val_hist.size() == NCH) begin
         for (int i = 0; i < NCH; i++) begin
            check("all4_ack_ch", 32'(ack_hist[i].k), 32'(i));
            check("all4_val_ch", 32'(val_hist[i].k), 32'(i));
            check("all4_val_cyc", 32'(val_hist[i].cyc - ack_hist[0].cyc),
                  32'(LAT + 2 + i));
         end
      end

      // ch0 and ch3 contend continuously.
      do_reset();
      clear_hist();
      for (int i = 0; i < 6; i++) begin
         push(0, W'($urandom), W'($urandom));
         push(3, W'($urandom), W'($urandom));
      end
      drain();
      check("pair_acks", 32'(ack_hist.size()), 32'd12);
      if (ack_hist.size() == 12) begin
         for (int i = 0; i < 12; i++) begin
`ifdef MPSHARE_ROUNDROBIN_EN
            k = (i % 2 == 0) ? 0 : 3;
`else
            k = (i < 6) ? 0 : 3;
`endif
            check("pair_order", 32'(ack_hist[i].k), 32'(k));
         end
      end

      // Reset while three operations are in flight.
      do_reset();
      clear_hist();
      for (int i = 0; i < 3; i++) push(i, W'($urandom), W'($urandom));
      t = 0;
      while (ack_hist.size() < 3 && t < 30) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("flight_acks", 32'(ack_hist.size()), 32'd3);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      val_hist.delete();
      @(negedge clk);
      check("mid_mpcand", 32'(mpcand_o), 32'd0);
      check("mid_mplier", 32'(mplier_o), 32'd0);
      check("mid_mprod", 32'(mprod_o), 32'd0);
      check("mid_valid", 32'(valid_o), 32'd0);
      tick(10);
      check("mid_no_valid", 32'(val_hist.size()), 32'd0);
      clear_hist();
      push(1, 24'h200000, 24'h300000);
      wait_val(1);
      if (val_hist.size() > 0 && ack_hist.size() > 0) begin
         check("post_ch", 32'(val_hist[0].k), 32'd1);
         check("post_prod", 32'(val_hist[0].p), 32'h0c0000);
         check("post_lat", 32'(val_hist[0].cyc - ack_hist[0].cyc),
               32'(LAT + 2));
      end
      drain();

      // Request presented in the reset cycle is not acked there.
      clear_hist();
      push(3, W'($urandom), W'($urandom));
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      #1;
      check("rst_wins_ack", 32'(ack_o), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      drain();
      check("rst_wins_n", 32'(ack_hist.size()), 32'd1);
      if (ack_hist.size() == 1) begin
         check("rst_wins_ch", 32'(ack_hist[0].k), 32'd3);
      end

      // Random traffic across channels with random gaps.
      clear_hist();
      for (int i = 0; i < NCH; i++) begin
         cnt[i] = 0;
         got[i] = 0;
      end
      for (int i = 0; i < 32; i++) begin
         k = int'($urandom_range(0, NCH - 1));
         push(k, W'($urandom), W'($urandom));
         cnt[k]++;
         tick(int'($urandom_range(0, 3)));
      end
      drain();
      check("rand_total", 32'(val_hist.size()), 32'd32);
      foreach (val_hist[i]) begin
         if (val_hist[i].k >= 0) got[val_hist[i].k]++;
      end
      for (int i = 0; i < NCH; i++) begin
         check("rand_per_ch", 32'(got[i]), 32'(cnt[i]));
      end

      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
